// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer owning the PC, feeding a prefetch queue to decode.
//   clk, rst_n (async, active-low); run gates new fetches; imem_addr/imem_data drive the
//   combinational-read instruction memory; redirect_valid/redirect_pc flush and retarget;
//   if_valid/if_ready/if_inst/if_pc/if_pc_plus1 form the decode handshake; buf_count is
//   queue occupancy; halted reports halt detection.
//   Optional macro IFETCH_HALT_DETECT_EN enables the HALT state on the all-ones word.
module ifetch_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int INST_W    = 19,
  parameter int RESET_PC  = 0,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INST_W-1:0]            imem_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         if_valid,
  input  logic                         if_ready,
  output logic [INST_W-1:0]            if_inst,
  output logic [ADDR_W-1:0]            if_pc,
  output logic [ADDR_W-1:0]            if_pc_plus1,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic                         halted
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  logic [1:0] state, state_nx, run_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] q_pc [BUF_DEPTH];
  logic [INST_W-1:0] q_inst [BUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic enq, deq;
  assign deq = if_valid & if_ready;
  assign enq = (state == S_FETCH) & ~redirect_valid & ((count < CW'(BUF_DEPTH)) | deq);
  assign run_state = (state == S_IDLE && run) ? S_FETCH : (state == S_FETCH && !run) ? S_IDLE : state;
`ifdef IFETCH_HALT_DETECT_EN
  localparam logic [1:0] S_HALT = 2'd2;
  // leaving HALT via redirect re-evaluates run; other states keep their state on redirect
  assign state_nx = redirect_valid ? ((state == S_HALT) ? (run ? S_FETCH : S_IDLE) : state)
                  : (enq & (&imem_data)) ? S_HALT : run_state;
  assign halted = (state == S_HALT);
`else
  assign state_nx = redirect_valid ? state : run_state;
  assign halted = 1'b0;
`endif
  assign imem_addr   = pc;
  assign if_valid    = (count != '0);
  assign if_inst     = q_inst[head];
  assign if_pc       = q_pc[head];
  assign if_pc_plus1 = if_valid ? if_pc + ADDR_W'(1) : '0;
  assign buf_count   = count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= ADDR_W'(RESET_PC);
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (redirect_valid) begin
        pc    <= redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          q_pc[tail]   <= pc;
          q_inst[tail] <= imem_data;
          tail         <= tail + PW'(1);
          pc           <= pc + ADDR_W'(1);
        end
        if (deq) head <= head + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: randomized and directed checks of ifetch_ctrl against a queue-based reference model.
module tb_ifetch_ctrl;
`ifdef IFETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic [11:0] imem_addr;
  logic [18:0] imem_data;
  logic redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic if_valid;
  logic if_ready = 1'b0;
  logic [18:0] if_inst;
  logic [11:0] if_pc, if_pc_plus1;
  logic [1:0] buf_count;
  logic halted;
  logic [18:0] mem [4096];
  logic [30:0] mq [$];
  logic [11:0] mpc = '0;
  bit mfetch = 1'b0;
  bit mhalt = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
    .buf_count(buf_count), .halted(halted)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic compare_all();
    logic [30:0] h;
    logic [11:0] hp1;
    check("if_valid", 32'(if_valid), 32'(mq.size() != 0));
    check("buf_count", 32'(buf_count), 32'(mq.size()));
    check("imem_addr", 32'(imem_addr), 32'(mpc));
    check("halted", 32'(halted), 32'(mhalt));
    if (mq.size() != 0) begin
      h = mq[0];
      hp1 = h[30:19] + 12'd1;
      check("if_pc", 32'(if_pc), 32'(h[30:19]));
      check("if_inst", 32'(if_inst), 32'(h[18:0]));
      check("if_pc_plus1", 32'(if_pc_plus1), 32'(hp1));
    end
  endtask
  task automatic step(input bit r, input bit rdy, input bit rv, input logic [11:0] rpc);
    bit d, e;
    run = r;
    if_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    d = (mq.size() != 0) && rdy;
    if (rv) begin
      mq.delete();
      mpc = rpc;
      if (mhalt) begin
        mhalt = 1'b0;
        mfetch = r;
      end
    end else begin
      e = mfetch && !mhalt && (mq.size() < 2 || d);
      if (d) void'(mq.pop_front());
      if (e) begin
        mq.push_back({mpc, mem[mpc]});
        if (HALT_EN && mem[mpc] == 19'h7FFFF) mhalt = 1'b1;
        mpc = mpc + 12'd1;
      end
      if (!mhalt) mfetch = r;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask
  task automatic model_reset();
    mq.delete();
    mpc = '0;
    mfetch = 1'b0;
    mhalt = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 19'($urandom);
      if (mem[i] == 19'h7FFFF) mem[i] = '0;
    end
    mem[3] = 19'h7FFFF;
    #12;
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_buf_count", 32'(buf_count), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_if_inst", 32'(if_inst), 0);
    check("rst_if_pc", 32'(if_pc), 0);
    check("rst_if_pc_plus1", 32'(if_pc_plus1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 12'h000);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 12'h004);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 12'h100);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 12'hFFE);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 12'h000);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 12'h010);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [11:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
      step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, rp);
    end
    step(1, 1, 1, 12'h200);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_if_valid", 32'(if_valid), 0);
    check("async_imem_addr", 32'(imem_addr), 0);
    check("async_buf_count", 32'(buf_count), 0);
    check("async_halted", 32'(halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
